// File: rtl/chip_bus_arbiter.sv
// Chip-RAM slot arbiter: splits each 2-CLK memory slot between Agnus DMA and the 68000,
// generating RAS/CAS, data-buffer direction, CPU DTACK and the blitter-slowdown request.
module chip_bus_arbiter #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 4
) (
  input  logic CLK,
  input  logic _RST,
  input  logic _AS,
  input  logic _RE,
  input  logic R_W,
  input  logic DMA_REQ,
  input  logic DMA_PRI,
  input  logic BLIT_NASTY,
  output logic SLOT_PH,
  output logic DMA_ACK,
  output logic CPU_ACK,
  output logic _RAS,
  output logic _CAS,
  output logic _CDR,
  output logic _CDW,
  output logic _DTACK_O,
  output logic _BLS
);

  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    OWN_IDLE,
    OWN_DMA,
    OWN_CPU
  } owner_e;

  owner_e           owner_q, owner_d;
  logic             slot_ph_q, slot_ph_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bls_q, bls_d;
  logic             cpu_done_q, cpu_done_d;
  logic             dtack_q, dtack_d;
  logic             cdr_q, cdr_d;
  logic             cdw_q, cdw_d;
  logic             rw_q, rw_d;
  logic             cpu_pend;
  logic             starved;

  always_ff @(posedge CLK) begin
    if (!_RST) begin
      owner_q    <= OWN_IDLE;
      slot_ph_q  <= 1'b0;
      cnt_q      <= '0;
      bls_q      <= 1'b0;
      cpu_done_q <= 1'b0;
      dtack_q    <= 1'b0;
      cdr_q      <= 1'b0;
      cdw_q      <= 1'b0;
      rw_q       <= 1'b1;
    end else begin
      owner_q    <= owner_d;
      slot_ph_q  <= slot_ph_d;
      cnt_q      <= cnt_d;
      bls_q      <= bls_d;
      cpu_done_q <= cpu_done_d;
      dtack_q    <= dtack_d;
      cdr_q      <= cdr_d;
      cdw_q      <= cdw_d;
      rw_q       <= rw_d;
    end
  end

  // Owner, starvation count and _BLS only change on the edge that ends phase 1.
  always_comb begin
    owner_d    = owner_q;
    slot_ph_d  = ~slot_ph_q;
    cnt_d      = cnt_q;
    bls_d      = bls_q;
    cpu_done_d = cpu_done_q;
    dtack_d    = dtack_q;
    cdr_d      = cdr_q;
    cdw_d      = cdw_q;
    rw_d       = rw_q;
    cpu_pend   = !_AS && !_RE && !cpu_done_q;
    starved    = (cnt_q >= LIMIT);

    if (slot_ph_q) begin
      if (DMA_PRI)                                owner_d = OWN_DMA;
      else if (cpu_pend && starved && !BLIT_NASTY) owner_d = OWN_CPU;
      else if (DMA_REQ)                           owner_d = OWN_DMA;
      else if (cpu_pend)                          owner_d = OWN_CPU;
      else                                        owner_d = OWN_IDLE;

      if (cpu_pend && (owner_d != OWN_CPU))
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      else
        cnt_d = '0;

      bls_d = starved;
      rw_d  = R_W;
    end

    // DTACK and buffer enables hold until the CPU ends its bus cycle by raising _AS.
    if (!slot_ph_q && (owner_q == OWN_CPU)) begin
      dtack_d    = 1'b1;
      cdr_d      = rw_q;
      cdw_d      = !rw_q;
      cpu_done_d = 1'b1;
    end else if (cpu_done_q && _AS) begin
      dtack_d    = 1'b0;
      cdr_d      = 1'b0;
      cdw_d      = 1'b0;
      cpu_done_d = 1'b0;
    end
  end

  always_comb begin
    SLOT_PH  = slot_ph_q;
    DMA_ACK  = (owner_q == OWN_DMA);
    CPU_ACK  = (owner_q == OWN_CPU);
    _RAS     = (owner_q == OWN_IDLE);
    _CAS     = !((owner_q != OWN_IDLE) && slot_ph_q);
    _CDR     = !cdr_q;
    _CDW     = !cdw_q;
    _DTACK_O = !dtack_q;
    _BLS     = !bls_q;
  end

endmodule

// File: tb/tb_chip_bus_arbiter.sv
// Directed bench for chip_bus_arbiter: each clock pushes the expected output vector,
// which is popped and compared one time unit after the rising edge.
module tb_chip_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n, as_n, re_n, r_w, dma_req, dma_pri, blit_nasty;
  logic slot_ph, dma_ack, cpu_ack, ras_n, cas_n, cdr_n, cdw_n, dtack_n, bls_n;

  typedef struct {
    string      tag;
    logic [8:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   exp_ph = 1'b0;

  localparam int IDLE = 0;
  localparam int DMA  = 1;
  localparam int CPU  = 2;

  chip_bus_arbiter #(.STARVE_LIMIT(3), .CNT_W(4)) dut (
    .CLK        (clk),
    ._RST       (rst_n),
    ._AS        (as_n),
    ._RE        (re_n),
    .R_W        (r_w),
    .DMA_REQ    (dma_req),
    .DMA_PRI    (dma_pri),
    .BLIT_NASTY (blit_nasty),
    .SLOT_PH    (slot_ph),
    .DMA_ACK    (dma_ack),
    .CPU_ACK    (cpu_ack),
    ._RAS       (ras_n),
    ._CAS       (cas_n),
    ._CDR       (cdr_n),
    ._CDW       (cdw_n),
    ._DTACK_O   (dtack_n),
    ._BLS       (bls_n)
  );

  always #5 clk = ~clk;

  // Vector order: SLOT_PH, DMA_ACK, CPU_ACK, _RAS, _CAS, _CDR, _CDW, _DTACK_O, _BLS
  function automatic logic [8:0] mk(input bit ph, input int own, input bit dt,
                                    input bit rd, input bit wr, input bit bls_low);
    logic [8:0] v;
    v = {ph, own == DMA, own == CPU, own == IDLE, !((own != IDLE) && ph),
         !rd, !wr, !dt, !bls_low};
    return v;
  endfunction

  task automatic applyStimulus(input logic rst, input logic as, input logic re, input logic rw,
                               input logic dreq, input logic dpri, input logic nasty);
    rst_n      = rst;
    as_n       = as;
    re_n       = re;
    r_w        = rw;
    dma_req    = dreq;
    dma_pri    = dpri;
    blit_nasty = nasty;
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [8:0] obs;
    obs = {slot_ph, dma_ack, cpu_ack, ras_n, cas_n, cdr_n, cdw_n, dtack_n, bls_n};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.vec) else begin
        errors++;
        $error("[TB] FAIL %s observed=%b expected=%b", e.tag, obs, e.vec);
      end
    end
  endtask

  task automatic tick(input string tag, input int own, input bit dt, input bit rd,
                      input bit wr, input bit bls_low);
    exp_ph = (rst_n === 1'b0) ? 1'b0 : !exp_ph;
    sb_q.push_back('{tag, mk(exp_ph, own, dt, rd, wr, bls_low)});
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    // Reset, then idle slots
    applyStimulus(0, 1, 1, 1, 0, 0, 0);
    tick("reset", IDLE, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick($sformatf("idle_%0d", i), IDLE, 0, 0, 0, 0);

    // CPU read with no DMA, DTACK held until _AS rises
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    tick("rd_wait_p1", IDLE, 0, 0, 0, 0);
    tick("rd_slot_p0", CPU, 0, 0, 0, 0);
    tick("rd_slot_p1", CPU, 1, 1, 0, 0);
    tick("rd_hold_0", IDLE, 1, 1, 0, 0);
    tick("rd_hold_1", IDLE, 1, 1, 0, 0);
    tick("rd_hold_2", IDLE, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 1, 0, 0, 0);
    tick("rd_release", IDLE, 0, 0, 0, 0);

    // CPU against continuous DMA_REQ: starvation override on the fourth slot
    applyStimulus(1, 0, 0, 1, 1, 0, 0);
    for (int s = 1; s <= 3; s++) begin
      tick($sformatf("starve_s%0d_p0", s), DMA, 0, 0, 0, 0);
      tick($sformatf("starve_s%0d_p1", s), DMA, 0, 0, 0, 0);
    end
    tick("starve_s4_p0", CPU, 0, 0, 0, 1);
    tick("starve_s4_p1", CPU, 1, 1, 0, 1);
    tick("starve_s5_p0", DMA, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 1, 1, 0, 0);
    tick("starve_s5_p1", DMA, 0, 0, 0, 0);

    // Blitter-nasty blocks the override; counter must saturate, not wrap
    applyStimulus(1, 0, 0, 1, 1, 0, 1);
    for (int s = 1; s <= 20; s++) begin
      tick($sformatf("nasty_s%0d_p0", s), DMA, 0, 0, 0, s >= 4);
      tick($sformatf("nasty_s%0d_p1", s), DMA, 0, 0, 0, s >= 4);
    end
    applyStimulus(1, 0, 0, 1, 1, 0, 0);
    tick("nasty_off_p0", CPU, 0, 0, 0, 1);
    tick("nasty_off_p1", CPU, 1, 1, 0, 1);
    applyStimulus(1, 1, 1, 1, 0, 0, 0);
    tick("nasty_release", IDLE, 0, 0, 0, 0);

    // Fixed-priority DMA beats a starved CPU
    applyStimulus(1, 0, 0, 1, 0, 1, 0);
    tick("pri_wait_p1", IDLE, 0, 0, 0, 0);
    for (int s = 1; s <= 6; s++) begin
      tick($sformatf("pri_s%0d_p0", s), DMA, 0, 0, 0, s >= 4);
      tick($sformatf("pri_s%0d_p1", s), DMA, 0, 0, 0, s >= 4);
    end
    applyStimulus(1, 0, 0, 1, 0, 0, 0);
    tick("pri_off_p0", CPU, 0, 0, 0, 1);
    tick("pri_off_p1", CPU, 1, 1, 0, 1);
    applyStimulus(1, 1, 1, 1, 0, 0, 0);
    tick("pri_release", IDLE, 0, 0, 0, 0);

    // CPU write interrupted by reset in phase 1, then granted afresh
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick("wr_wait_p1", IDLE, 0, 0, 0, 0);
    tick("wr_slot_p0", CPU, 0, 0, 0, 0);
    tick("wr_slot_p1", CPU, 1, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    tick("wr_reset", IDLE, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    tick("wr_post_p1", IDLE, 0, 0, 0, 0);
    tick("wr_regrant_p0", CPU, 0, 0, 0, 0);
    tick("wr_regrant_p1", CPU, 1, 0, 1, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0);
    tick("wr_release", IDLE, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
